snake_engine: RTL and testbench

Snake movement engine; the consumer of the one-cycle `game_tick` strobe from the game-tick clock divider. Each tick advances the snake one grid cell in the latched direction, checks wall and self collision, and grows the body when the head lands on the food cell. A circular segment buffer with an indexed read port serves the VGA renderer and the food placer.

---
 rtl/snake_pkg.sv | 36 +++
 rtl/snake_body_buf.sv | 93 +++++++++
 rtl/snake_engine.sv | 209 ++++++++++++++++++++
 tb/tb_snake_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake engine: directions, FSM states, segment record.
package snake_pkg;

  localparam int COORD_W = 5;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN,
    ST_MOVE,
    ST_OVER
  } state_e;

  // One body cell; 10 bits per entry in the segment buffer.
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } seg_t;

  function automatic dir_e reverse_dir(input dir_e d);
    case (d)
      DIR_UP:   reverse_dir = DIR_DOWN;
      DIR_DOWN: reverse_dir = DIR_UP;
      DIR_LEFT: reverse_dir = DIR_RIGHT;
      default:  reverse_dir = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_body_buf.sv
// Circular segment buffer. Segment i lives at (head_ptr - i) mod MAX_LEN, so a
// move is a pointer increment plus one write; the old tail is overwritten only
// when the buffer is full.
module snake_body_buf
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int IDX_W    = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             wr_en,
  input  seg_t             wr_seg,
  input  logic [IDX_W-1:0] scan_idx,
  output seg_t             scan_seg,
  output seg_t             head_seg,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [IDX_W:0]   rd_len,
  output seg_t             rd_seg,
  output logic             rd_valid
);

  localparam logic [IDX_W-1:0] INIT_PTR = IDX_W'(INIT_LEN - 1);

  seg_t             mem_q    [MAX_LEN];
  seg_t             mem_d    [MAX_LEN];
  seg_t             init_mem [MAX_LEN];
  logic [IDX_W-1:0] head_ptr_q, head_ptr_d;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] scan_ptr;
  logic [IDX_W-1:0] rd_ptr;
  seg_t             rd_seg_q, rd_seg_d;
  logic             rd_valid_q, rd_valid_d;

  // Starting snake: horizontal line ending at the grid centre, head rightmost.
  always_comb begin
    for (int j = 0; j < MAX_LEN; j++) begin
      init_mem[j] = '0;
      if (j < INIT_LEN) begin
        init_mem[j].x = COORD_W'(GRID_W / 2 - (INIT_LEN - 1) + j);
        init_mem[j].y = COORD_W'(GRID_H / 2);
      end
    end
  end

  // Body update: full reload on start, otherwise push a new head on wr_en.
  always_comb begin
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    wr_ptr     = head_ptr_q + IDX_W'(1);
    if (init) begin
      mem_d      = init_mem;
      head_ptr_d = INIT_PTR;
    end else if (wr_en) begin
      head_ptr_d    = wr_ptr;
      mem_d[wr_ptr] = wr_seg;
    end
  end

  assign scan_ptr = head_ptr_q - scan_idx;
  assign rd_ptr   = head_ptr_q - rd_idx;
  assign scan_seg = mem_q[scan_ptr];
  assign head_seg = mem_q[head_ptr_q];

  // Renderer read port; reads pre-update contents so a MOVE-cycle read sees the old body.
  always_comb begin
    rd_seg_d   = mem_q[rd_ptr];
    rd_valid_d = ({1'b0, rd_idx} < rd_len);
  end

  // Storage and read-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= init_mem;
      head_ptr_q <= INIT_PTR;
      rd_seg_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_ptr_q <= head_ptr_d;
      rd_seg_q   <= rd_seg_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_seg   = rd_seg_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/snake_engine.sv
// Snake movement engine: direction latch, tick-driven step, wall check, serial
// self-collision scan and body growth. game_tick is a one-cycle strobe with no
// back-pressure; a tick arriving outside RUN is dropped, never queued.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic                       game_tick,
  input  logic                       start,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic [COORD_W-1:0]         food_x,
  input  logic [COORD_W-1:0]         food_y,
  input  logic [$clog2(MAX_LEN)-1:0] seg_idx,
  output logic [COORD_W-1:0]         seg_x,
  output logic [COORD_W-1:0]         seg_y,
  output logic                       seg_valid,
  output logic [COORD_W-1:0]         head_x,
  output logic [COORD_W-1:0]         head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       ate,
  output logic                       running,
  output logic                       game_over,
  output logic [2:0]                 dbg_state
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  dir_e             last_dir_q, last_dir_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [LEN_W-1:0] scan_idx_q, scan_idx_d;
  logic [LEN_W-1:0] scan_last;
  logic             grow_q, grow_d;
  seg_t             next_q, next_d;
  logic             ate_q, ate_d;

  logic             init;
  logic             wr_en;
  seg_t             head_seg;
  seg_t             scan_seg;
  seg_t             rd_seg;
  seg_t             step_seg;
  seg_t             food;
  logic             hit_wall;
  logic             btn_valid;
  dir_e             btn_dir;
  dir_e             ref_dir;

  snake_body_buf #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN)
  ) u_body (
    .clk     (clk_100MHz),
    .reset   (reset),
    .init    (init),
    .wr_en   (wr_en),
    .wr_seg  (next_q),
    .scan_idx(scan_idx_q[IDX_W-1:0]),
    .scan_seg(scan_seg),
    .head_seg(head_seg),
    .rd_idx  (seg_idx),
    .rd_len  (length_q),
    .rd_seg  (rd_seg),
    .rd_valid(seg_valid)
  );

  assign food = '{y: food_y, x: food_x};

  // Button priority up > down > left > right.
  always_comb begin
    btn_valid = 1'b1;
    btn_dir   = DIR_RIGHT;
    if (btn_up)         btn_dir = DIR_UP;
    else if (btn_down)  btn_dir = DIR_DOWN;
    else if (btn_left)  btn_dir = DIR_LEFT;
    else if (btn_right) btn_dir = DIR_RIGHT;
    else                btn_valid = 1'b0;
  end

  // Candidate head for the pending direction and whether it leaves the grid.
  always_comb begin
    step_seg = head_seg;
    hit_wall = 1'b0;
    case (dir_q)
      DIR_UP: begin
        hit_wall   = (head_seg.y == '0);
        step_seg.y = head_seg.y - COORD_W'(1);
      end
      DIR_DOWN: begin
        hit_wall   = (head_seg.y == COORD_W'(GRID_H - 1));
        step_seg.y = head_seg.y + COORD_W'(1);
      end
      DIR_LEFT: begin
        hit_wall   = (head_seg.x == '0);
        step_seg.x = head_seg.x - COORD_W'(1);
      end
      default: begin
        hit_wall   = (head_seg.x == COORD_W'(GRID_W - 1));
        step_seg.x = head_seg.x + COORD_W'(1);
      end
    endcase
  end

  // In the tick cycle the move about to happen is dir_q, so reversals are judged against it.
  assign ref_dir   = game_tick ? dir_q : last_dir_q;
  // Tail cell is excluded when not growing because it is vacated by this move.
  assign scan_last = grow_q ? (length_q - LEN_W'(1)) : (length_q - LEN_W'(2));

  // FSM next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    length_d   = length_q;
    scan_idx_d = scan_idx_q;
    grow_d     = grow_q;
    next_d     = next_q;
    ate_d      = 1'b0;
    init       = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          init       = 1'b1;
          dir_d      = DIR_RIGHT;
          last_dir_d = DIR_RIGHT;
          length_d   = LEN_W'(INIT_LEN);
          grow_d     = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (btn_valid && (btn_dir != reverse_dir(ref_dir))) dir_d = btn_dir;
        if (game_tick) begin
          last_dir_d = dir_q;
          if (hit_wall) begin
            state_d = ST_OVER;
          end else begin
            next_d     = step_seg;
            grow_d     = (step_seg == food);
            scan_idx_d = '0;
            state_d    = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (scan_seg == next_q)          state_d = ST_OVER;
        else if (scan_idx_q == scan_last) state_d = ST_MOVE;
        else                              scan_idx_d = scan_idx_q + LEN_W'(1);
      end
      ST_MOVE: begin
        wr_en = 1'b1;
        if (grow_q) begin
          ate_d = 1'b1;
          if (length_q != LEN_W'(MAX_LEN)) length_d = length_q + LEN_W'(1);
        end
        state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and control registers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_RIGHT;
      last_dir_q <= DIR_RIGHT;
      length_q   <= LEN_W'(INIT_LEN);
      scan_idx_q <= '0;
      grow_q     <= 1'b0;
      next_q     <= '0;
      ate_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      length_q   <= length_d;
      scan_idx_q <= scan_idx_d;
      grow_q     <= grow_d;
      next_q     <= next_d;
      ate_q      <= ate_d;
    end
  end

  assign head_x    = head_seg.x;
  assign head_y    = head_seg.y;
  assign seg_x     = rd_seg.x;
  assign seg_y     = rd_seg.y;
  assign length    = length_q;
  assign ate       = ate_q;
  assign running   = (state_q == ST_RUN) || (state_q == ST_SCAN) || (state_q == ST_MOVE);
  assign game_over = (state_q == ST_OVER);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with default parameters (32x24 grid, 64 max, 3 initial).
module tb_snake_engine;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_tick = 1'b0;
  logic       start = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [4:0] food_x = '0, food_y = '0;
  logic [5:0] seg_idx = '0;
  logic [4:0] seg_x, seg_y, head_x, head_y;
  logic       seg_valid, ate, running, game_over;
  logic [6:0] length;
  logic [2:0] dbg_state;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int n;

  // clock / reset
  always #5 clk = ~clk;

  snake_engine #(
    .GRID_W(32), .GRID_H(24), .MAX_LEN(64), .INIT_LEN(3)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .game_tick (game_tick),
    .start     (start),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .food_x    (food_x),
    .food_y    (food_y),
    .seg_idx   (seg_idx),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .seg_valid (seg_valid),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .ate       (ate),
    .running   (running),
    .game_over (game_over),
    .dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    assert (obs === exp_v) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, ".head_x"}, 32'(head_x), x);
    check({tag, ".head_y"}, 32'(head_y), y);
  endtask

  task automatic read_seg(input string tag, input int idx, input int x, input int y, input int v);
    seg_idx = 6'(idx);
    step();
    check({tag, ".seg_x"}, 32'(seg_x), x);
    check({tag, ".seg_y"}, 32'(seg_y), y);
    check({tag, ".seg_valid"}, 32'(seg_valid), v);
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    step();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  // Pulses a tick and counts cycles until the FSM settles in RUN or OVER (bounded).
  task automatic tick_wait(output int cyc);
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    cyc = 1;
    while (!(dbg_state == ST_RUN || dbg_state == ST_OVER) && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic move(input string tag, input int exp_cyc, input int x, input int y);
    int c;
    tick_wait(c);
    check({tag, ".latency"}, c, exp_cyc);
    check_head(tag, x, y);
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_head("rst", 16, 12);
    check("rst.length", 32'(length), 3);
    check("rst.ate", 32'(ate), 0);
    check("rst.running", 32'(running), 0);
    check("rst.game_over", 32'(game_over), 0);
    check("rst.seg_x", 32'(seg_x), 0);
    check("rst.seg_valid", 32'(seg_valid), 0);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
    read_seg("rst.seg2", 2, 14, 12, 1);
    read_seg("rst.seg3", 3, 0, 0, 0);

    // tick in IDLE is dropped
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    step();
    check("idle_tick.state", 32'(dbg_state), 32'(ST_IDLE));
    check_head("idle_tick", 16, 12);

    // start
    start = 1'b1;
    step();
    start = 1'b0;
    check("start.running", 32'(running), 1);
    check("start.state", 32'(dbg_state), 32'(ST_RUN));

    // first move right: 2 + L = 4 cycles with L = 2
    move("t1", 4, 17, 12);
    check("t1.length", 32'(length), 3);
    check("t1.ate", 32'(ate), 0);
    read_seg("t1.seg2", 2, 15, 12, 1);

    // up then down before one tick: last accepted (down) wins
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    move("t2", 4, 17, 13);

    // up is a reversal of the last move (down) and is ignored
    press(1, 0, 0, 0);
    move("t3", 4, 17, 14);

    // left and right together: left has priority
    press(0, 0, 1, 1);
    move("t4", 4, 16, 14);

    // food ahead: grow scan covers whole body (L = 3)
    food_x = 5'd15; food_y = 5'd14;
    move("food1", 5, 15, 14);
    check("food1.ate", 32'(ate), 1);
    check("food1.length", 32'(length), 4);
    food_x = 5'd0; food_y = 5'd0;
    read_seg("food1.tail", 3, 17, 13, 1);
    check("food1.ate_pulse", 32'(ate), 0);

    // loop around into the cell the tail vacates: no collision
    press(1, 0, 0, 0);
    move("loop_up", 5, 15, 13);
    press(0, 0, 0, 1);
    move("loop_right", 5, 16, 13);
    press(0, 1, 0, 0);
    move("loop_tail", 5, 16, 14);
    check("loop_tail.game_over", 32'(game_over), 0);
    check("loop_tail.length", 32'(length), 4);

    // grow to length 5
    food_x = 5'd16; food_y = 5'd15;
    move("food2", 6, 16, 15);
    check("food2.ate", 32'(ate), 1);
    check("food2.length", 32'(length), 5);
    food_x = 5'd0; food_y = 5'd0;

    // turn left, up, then right into segment 3
    press(0, 0, 1, 0);
    move("self_left", 6, 15, 15);
    press(1, 0, 0, 0);
    move("self_up", 6, 15, 14);
    press(0, 0, 0, 1);
    tick_wait(n);
    check("self.latency", n, 5);
    check("self.game_over", 32'(game_over), 1);
    check("self.running", 32'(running), 0);
    check_head("self", 15, 14);
    check("self.length", 32'(length), 5);

    // OVER is frozen; read port still serves the body
    press(0, 1, 0, 0);
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    step();
    check_head("over_frozen", 15, 14);
    check("over_frozen.state", 32'(dbg_state), 32'(ST_OVER));
    read_seg("over.seg3", 3, 16, 14, 1);

    // restart restores the reset snake
    start = 1'b1;
    step();
    start = 1'b0;
    check_head("restart", 16, 12);
    check("restart.length", 32'(length), 3);
    check("restart.game_over", 32'(game_over), 0);
    check("restart.running", 32'(running), 1);
    read_seg("restart.seg2", 2, 14, 12, 1);
    read_seg("restart.seg3", 3, 0, 0, 0);

    // run right to x = 31, then into the wall
    for (int i = 0; i < 15; i++) begin
      tick_wait(n);
      check("wall_run.latency", n, 4);
    end
    check_head("wall_edge", 31, 12);
    tick_wait(n);
    check("wall.latency", n, 1);
    check("wall.game_over", 32'(game_over), 1);
    check_head("wall", 31, 12);
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    step();
    check_head("wall_frozen", 31, 12);

    // reset mid-SCAN on a growing move; start alongside reset is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    food_x = 5'd17; food_y = 5'd12;
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    check("scan.state", 32'(dbg_state), 32'(ST_SCAN));
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("scan_rst.state", 32'(dbg_state), 32'(ST_IDLE));
    check_head("scan_rst", 16, 12);
    check("scan_rst.length", 32'(length), 3);
    check("scan_rst.ate", 32'(ate), 0);
    check("scan_rst.running", 32'(running), 0);
    check("scan_rst.seg_valid", 32'(seg_valid), 0);
    step();
    check("scan_rst.ate_after", 32'(ate), 0);
    check("scan_rst.state_after", 32'(dbg_state), 32'(ST_IDLE));
    check_head("scan_rst_after", 16, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
